// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache control FSM: state encoding and width helpers.
package dcache_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WB,
        FILL,
        SNP,
        FL_CHK,
        FL_REQ,
        FL_WB,
        FL_NXT,
        HALT
    } dcache_state_t;

    // Word-offset width for a block of `words` words (never narrower than one bit).
    function automatic int offw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Frame-index width for a flush walk over `frames` frames.
    function automatic int frw(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

    // Burst states move one data word per completed memory beat.
    function automatic logic is_burst(input dcache_state_t s);
        return (s == WB) || (s == FILL) || (s == SNP) || (s == FL_WB);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-value flag.
// Used both for the word beat within a block and for the flush frame walk.
module beat_counter #(
    parameter int          W    = 2,
    parameter int unsigned TERM = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         term
);

    // Count register: clear wins over enable so every new burst starts at zero.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == W'(TERM));

endmodule

// File: rtl/dcache_ctrl_gen.sv
// L1 dcache control FSM: miss writeback/fill, snoop writeback and the
// end-of-program flush walk. Word beat and flush frame counters live here.
module dcache_ctrl_gen
    import dcache_pkg::*;
#(
    parameter  int WORDS  = 2,
    parameter  int FRAMES = 16,
    localparam int OFFW   = offw(WORDS),
    localparam int FRW    = frw(FRAMES)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            dmemREN,
    input  logic            dmemWEN,
    input  logic            dhit,
    input  logic            dirty,
    input  logic            sameaddr,
    input  logic            flush,
    input  logic            dwait,
    input  logic            ccwait,
    input  logic            ccwrite,
    input  logic            ccinv,
    output logic            dREN,
    output logic            dWEN,
    output logic [OFFW-1:0] word_off,
    output logic [FRW-1:0]  frame_idx,
    output logic            invalid,
    output logic            snoopable,
    output logic            flushing,
    output logic            halt
);

    // One extra bit so the walk can count past the last frame without wrapping.
    localparam int FCW = FRW + 1;

    dcache_state_t  state, next_state;
    logic [FCW-1:0] frame_cnt;
    logic           miss, beat, last, beat_clear;
    logic           beat_term, frame_term, frame_done;

    assign miss       = (dmemREN | dmemWEN) & ~dhit;
    assign beat       = is_burst(state) & ~dwait;
    assign last       = beat_term & beat;
    assign beat_clear = is_burst(next_state) && (next_state != state);
    // The MSB term guards against ever walking past FRAMES.
    assign frame_done = frame_term | frame_cnt[FRW];
    assign frame_idx  = frame_cnt[FRW-1:0];

    beat_counter #(.W(OFFW), .TERM(WORDS - 1)) u_word (
        .clk   (CLK),
        .rst   (RST),
        .clear (beat_clear),
        .en    (beat),
        .count (word_off),
        .term  (beat_term)
    );

    beat_counter #(.W(FCW), .TERM(FRAMES)) u_frame (
        .clk   (CLK),
        .rst   (RST),
        .clear (state == IDLE),
        .en    (state == FL_NXT),
        .count (frame_cnt),
        .term  (frame_term)
    );

    // State register; reset aborts any burst in progress immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs; the per-beat invalid pulse also depends on the beat.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        next_state = state;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        invalid    = 1'b0;
        snoopable  = 1'b0;
        flushing   = 1'b0;
        halt       = 1'b0;
        case (state)
            IDLE: begin
                if (miss && !ccwait) begin
                    next_state = dirty ? WB : FILL;
                end else if (flush) begin
                    next_state = FL_CHK;
                end else if (ccwait && ccwrite) begin
                    next_state = SNP;
                end
            end
            WB: begin
                dWEN = 1'b1;
                if (last) begin
                    invalid    = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                dREN = 1'b1;
                if (last) begin
                    next_state = IDLE;
                end
            end
            SNP: begin
                dWEN = 1'b1;
                if (last) begin
                    invalid    = ccinv;
                    next_state = IDLE;
                end
            end
            FL_CHK: begin
                flushing  = 1'b1;
                snoopable = 1'b1;
                if (frame_done) begin
                    next_state = HALT;
                end else if (dirty) begin
                    next_state = FL_REQ;
                end else if (!ccwait) begin
                    next_state = FL_NXT;
                end
            end
            FL_REQ: begin
                flushing  = 1'b1;
                snoopable = 1'b1;
                dWEN      = 1'b1;
                if (sameaddr && ccwait) begin
                    next_state = FL_WB;
                end
            end
            FL_WB: begin
                flushing = 1'b1;
                dWEN     = 1'b1;
                if (last) begin
                    invalid    = 1'b1;
                    next_state = FL_NXT;
                end
            end
            FL_NXT: begin
                flushing   = 1'b1;
                snoopable  = 1'b1;
                next_state = FL_CHK;
            end
            HALT: begin
                halt = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl_gen.sv
// Self-checking bench for dcache_ctrl_gen (WORDS=4, FRAMES=16): a transaction-level
// model (queue of pending bursts plus a flush-walk position) predicts every output
// each cycle; directed sections pin the model with hand-computed values.
module tb_dcache_ctrl_gen;

    localparam int WORDS  = 4;
    localparam int FRAMES = 16;
    localparam int OFFW   = 2;
    localparam int FRW    = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic dmemREN, dmemWEN, dhit, dirty, sameaddr, flush, dwait, ccwait, ccwrite, ccinv;
    logic dREN, dWEN, invalid, snoopable, flushing, halt;
    logic [OFFW-1:0] word_off;
    logic [FRW-1:0]  frame_idx;
    logic [11:0]     dut_outs;

    dcache_ctrl_gen #(.WORDS(WORDS), .FRAMES(FRAMES)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dhit      (dhit),
        .dirty     (dirty),
        .sameaddr  (sameaddr),
        .flush     (flush),
        .dwait     (dwait),
        .ccwait    (ccwait),
        .ccwrite   (ccwrite),
        .ccinv     (ccinv),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .word_off  (word_off),
        .frame_idx (frame_idx),
        .invalid   (invalid),
        .snoopable (snoopable),
        .flushing  (flushing),
        .halt      (halt)
    );

    assign dut_outs = {dREN, dWEN, word_off, frame_idx, invalid, snoopable, flushing, halt};

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {K_WB, K_FILL, K_SNP, K_FLWB} kind_t;
    typedef enum int {LOOK, ASK, STEP} walk_t;

    kind_t m_bursts[$];   // pending block transfers, head is active
    int    m_beats;       // words already moved in the head transfer
    bit    m_walking;
    int    m_frame;
    walk_t m_walk;
    bit    m_halted;

    task automatic model_reset();
        m_bursts.delete();
        m_beats   = 0;
        m_walking = 1'b0;
        m_frame   = 0;
        m_walk    = LOOK;
        m_halted  = 1'b0;
    endtask

    function automatic logic [11:0] model_outputs();
        logic ren = 1'b0, wen = 1'b0, inv = 1'b0, snp = 1'b0, fl = 1'b0, hl = 1'b0;
        int   off = 0;
        int   fidx;
        fidx = m_walking ? (m_frame % FRAMES) : 0;
        if (m_halted) begin
            hl = 1'b1;
        end else if (m_bursts.size() != 0) begin
            off = m_beats;
            ren = (m_bursts[0] == K_FILL);
            wen = !ren;
            fl  = (m_bursts[0] == K_FLWB);
            if (!dwait && m_beats == WORDS - 1)
                inv = (m_bursts[0] == K_SNP) ? ccinv : (m_bursts[0] != K_FILL);
        end else if (m_walking) begin
            fl  = 1'b1;
            snp = 1'b1;
            wen = (m_walk == ASK);
        end
        return {ren, wen, OFFW'(off), FRW'(fidx), inv, snp, fl, hl};
    endfunction

    task automatic model_step();
        bit miss;
        if (m_halted) return;
        if (m_bursts.size() != 0) begin
            if (!dwait) begin
                m_beats++;
                if (m_beats == WORDS) begin
                    m_beats = 0;
                    if (m_bursts[0] == K_FLWB) m_walk = STEP;
                    void'(m_bursts.pop_front());
                end
            end
        end else if (m_walking) begin
            case (m_walk)
                LOOK: begin
                    if (m_frame == FRAMES) m_halted = 1'b1;
                    else if (dirty)        m_walk = ASK;
                    else if (!ccwait)      m_walk = STEP;
                end
                ASK: if (sameaddr && ccwait) m_bursts.push_back(K_FLWB);
                STEP: begin
                    m_frame++;
                    m_walk = LOOK;
                end
            endcase
        end else begin
            miss = (dmemREN || dmemWEN) && !dhit;
            if (miss && !ccwait) begin
                if (dirty) m_bursts.push_back(K_WB);
                m_bursts.push_back(K_FILL);
            end else if (flush) begin
                m_walking = 1'b1;
                m_frame   = 0;
                m_walk    = LOOK;
            end else if (ccwait && ccwrite) begin
                m_bursts.push_back(K_SNP);
            end
        end
    endtask

    // Compare process: outputs checked against the model mid-cycle, then the model advances.
    always @(negedge CLK) begin
        if (RST) begin
            model_reset();
            check("reset_outputs", {20'd0, dut_outs}, 32'd0);
        end else begin
            check("outputs", {20'd0, dut_outs}, {20'd0, model_outputs()});
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    bit [FRAMES-1:0] dirty_map;
    int req_wait, wb_done;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        dmemREN = 1'b0; dmemWEN = 1'b0; dhit = 1'b1; dirty = 1'b0; sameaddr = 1'b0;
        flush = 1'b0; dwait = 1'b0; ccwait = 1'b0; ccwrite = 1'b0; ccinv = 1'b0;
    endtask

    function automatic logic map_dirty();
        return (m_walking && m_frame < FRAMES) ? dirty_map[m_frame] : 1'b0;
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) tick();
        #1 check("reset_state", {20'd0, dut_outs}, 32'd0);
        RST = 1'b0;
    endtask

    task automatic do_snoop(input logic inv);
        tick(); ccwait = 1'b1; ccwrite = 1'b1; ccinv = inv;
        tick(); ccwait = 1'b0; ccwrite = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            #1;
            check("snp_dWEN", dWEN, 1);
            check("snp_off", word_off, i);
            check("snp_invalid", invalid, (i == WORDS - 1) && inv);
            tick();
        end
        #1 check("snp_done_idle", dWEN, 0);
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Clean miss, dwait=0: FILL for 4 cycles with word_off 0..3, IDLE on cycle 5.
        tick(); dmemREN = 1'b1; dhit = 1'b0;
        #1 check("clean_miss_idle_dREN", dREN, 0);
        for (int i = 0; i < WORDS; i++) begin
            tick(); dmemREN = 1'b0;
            #1;
            check("clean_fill_dREN", dREN, 1);
            check("clean_fill_off", word_off, i);
        end
        tick();
        #1 check("clean_fill_back_idle", dREN, 0);

        // Dirty store miss, each beat held by dwait for two cycles.
        tick(); dmemWEN = 1'b1; dhit = 1'b0; dirty = 1'b1; dwait = 1'b1;
        tick(); dmemWEN = 1'b0; dirty = 1'b0;
        for (int b = 0; b < WORDS; b++) begin
            for (int w = 0; w < 3; w++) begin
                dwait = (w < 2);
                #1;
                check("wb_dWEN", dWEN, 1);
                check("wb_off_held", word_off, b);
                check("wb_invalid", invalid, (b == WORDS - 1) && (w == 2));
                tick();
            end
        end
        dwait = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            #1;
            check("wb_then_fill_dREN", dREN, 1);
            check("wb_then_fill_off", word_off, i);
            tick();
        end
        #1 check("dirty_miss_back_idle", {dREN, dWEN}, 0);

        // Snoop writeback with and without invalidation.
        do_snoop(1'b1);
        do_snoop(1'b0);

        // Random miss/snoop traffic, no flush.
        for (int c = 0; c < 600; c++) begin
            tick();
            dmemREN  = ($urandom_range(0, 3) == 0);
            dmemWEN  = ($urandom_range(0, 3) == 0);
            dhit     = $urandom_range(0, 1);
            dirty    = $urandom_range(0, 1);
            dwait    = ($urandom_range(0, 2) == 0);
            ccwait   = ($urandom_range(0, 3) == 0);
            ccwrite  = $urandom_range(0, 1);
            ccinv    = $urandom_range(0, 1);
            sameaddr = $urandom_range(0, 1);
            flush    = 1'b0;
        end

        // Directed flush walk: frames 3 and 9 dirty; first request denied for 5 cycles.
        tick(); idle_inputs();
        dirty_map = '0;
        dirty_map[3] = 1'b1;
        dirty_map[9] = 1'b1;
        wb_done = 0;
        req_wait = 0;
        tick(); flush = 1'b1;
        for (int c = 0; c < 400 && !halt; c++) begin
            bit denied;
            tick();
            flush    = 1'b0;
            dwait    = ($urandom_range(0, 2) == 0);
            dirty    = map_dirty();
            sameaddr = 1'b0;
            ccwait   = 1'b0;
            denied   = 1'b0;
            if (m_walking && m_bursts.size() == 0 && m_walk == ASK) begin
                if (req_wait >= 5 || wb_done > 0) begin
                    sameaddr = 1'b1;
                    ccwait   = 1'b1;
                end else begin
                    ccwait = $urandom_range(0, 1);
                    denied = 1'b1;
                end
                req_wait++;
            end else begin
                req_wait = 0;
            end
            #1;
            if (denied) begin
                check("flreq_hold_dWEN", dWEN, 1);
                check("flreq_no_beat", word_off, 0);
            end
            if (invalid && flushing) begin
                check("flwb_frame", frame_idx, (wb_done == 0) ? 3 : 9);
                wb_done++;
            end
        end
        check("flush_two_bursts", wb_done, 2);
        check("flush_reaches_halt", halt, 1);
        check("halt_frame_idx", frame_idx, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            dmemREN = $urandom_range(0, 1); dhit = 1'b0; flush = $urandom_range(0, 1);
            ccwait = 1'b1; ccwrite = 1'b1;
            #1 check("halt_sticky", {halt, dREN, dWEN}, 3'b100);
        end

        // Randomised flush walk with random dirty map, bus grants and memory waits.
        do_reset();
        dirty_map = FRAMES'($urandom);
        tick(); flush = 1'b1;
        for (int c = 0; c < 3000 && !halt; c++) begin
            tick();
            flush    = $urandom_range(0, 1);
            dmemREN  = $urandom_range(0, 1);
            dhit     = $urandom_range(0, 1);
            dirty    = map_dirty();
            dwait    = ($urandom_range(0, 2) == 0);
            ccwait   = $urandom_range(0, 1);
            sameaddr = $urandom_range(0, 1);
            ccwrite  = $urandom_range(0, 1);
            ccinv    = $urandom_range(0, 1);
        end
        #1 check("random_walk_halt", halt, 1);

        // Reset asserted in the middle of a flush writeback burst.
        do_reset();
        tick(); flush = 1'b1;
        tick(); flush = 1'b0; dirty = 1'b1;
        tick(); dirty = 1'b0; sameaddr = 1'b1; ccwait = 1'b1;
        tick(); sameaddr = 1'b0; ccwait = 1'b0; dwait = 1'b0;
        tick(); dwait = 1'b1;
        #1 check("mid_flwb_state", {flushing, dWEN, snoopable, word_off}, {3'b110, 2'd1});
        RST = 1'b1;
        #1 check("async_reset_outputs", {20'd0, dut_outs}, 32'd0);
        tick(); RST = 1'b0; idle_inputs();
        #1;
        check("after_rst_halt", halt, 0);
        check("after_rst_frame_idx", frame_idx, 0);
        check("after_rst_word_off", word_off, 0);
        check("after_rst_dWEN", dWEN, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
